// File: rtl/adsr_envelope_stage.sv
// ---------------------------------------------------------------------------
// adsr_envelope_stage
//
// Purpose:
//    Applies a piecewise-linear ADSR gain to the unsigned oscillator sample.
//    The envelope level and state only move on the sample-rate strobe `tick`.
//    The wave x level multiply runs every clock through a two-stage pipeline
//    feeding the voice mixer / DAC path.
//
// Ports:
//    clk            system clock
//    rst            synchronous, active-high reset
//    tick           envelope update strobe (one-cycle pulse)
//    gate           note on (1) / note off (0)
//    attack_step    level increment per tick in ATTACK (0 behaves as 1)
//    decay_step     level decrement per tick in DECAY (0 behaves as 1)
//    sustain_level  hold level in SUSTAIN, tracked live
//    release_step   level decrement per tick in RELEASE (0 behaves as 1)
//    wave_in        unsigned oscillator sample
//    sample_out     enveloped sample, 2 cycles after wave_in / env_level
//    env_level      current envelope level
//    env_state      IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
//    busy           high whenever env_state is not IDLE
//
// Configuration:
//    ADSR_RETRIGGER_EN  when defined, a gate rising edge seen on a tick in
//                       DECAY, SUSTAIN or RELEASE restarts ATTACK from the
//                       current level instead of being ignored.
// ---------------------------------------------------------------------------
module adsr_envelope_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int ENV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  gate,
    input  logic [ENV_WIDTH-1:0]  attack_step,
    input  logic [ENV_WIDTH-1:0]  decay_step,
    input  logic [ENV_WIDTH-1:0]  sustain_level,
    input  logic [ENV_WIDTH-1:0]  release_step,
    input  logic [DATA_WIDTH-1:0] wave_in,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic [ENV_WIDTH-1:0]  env_level,
    output logic [2:0]            env_state,
    output logic                  busy
);

    localparam int PROD_WIDTH = DATA_WIDTH + ENV_WIDTH;
    localparam logic [ENV_WIDTH-1:0] LEVEL_MAX = {ENV_WIDTH{1'b1}};
    localparam logic [ENV_WIDTH-1:0] LEVEL_ONE = {{(ENV_WIDTH-1){1'b0}}, 1'b1};

`ifdef ADSR_RETRIGGER_EN
    localparam logic RETRIGGER_EN = 1'b1;
`else
    localparam logic RETRIGGER_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [ENV_WIDTH-1:0]   next_level;
    logic                   gate_prev;
    logic [PROD_WIDTH-1:0]  product_q;

    logic [ENV_WIDTH-1:0]   attack_eff;
    logic [ENV_WIDTH-1:0]   decay_eff;
    logic [ENV_WIDTH-1:0]   release_eff;
    logic [ENV_WIDTH:0]     attack_sum;
    logic [ENV_WIDTH:0]     decay_diff;
    logic [ENV_WIDTH:0]     release_diff;
    logic                   attack_full;
    logic                   decay_done;
    logic                   release_done;
    logic [ENV_WIDTH-1:0]   attack_level;
    logic [ENV_WIDTH-1:0]   release_level;
    logic                   retrigger;

    assign env_state = state;

    // Saturating step arithmetic shared by every state. All sums and
    // differences carry one extra bit so a carry (attack overshoot) or a
    // borrow (decay/release underflow) is visible instead of wrapping.
    // A zero step is promoted to one so the envelope can never stall.
    always_comb begin
        attack_eff    = (attack_step  == '0) ? LEVEL_ONE : attack_step;
        decay_eff     = (decay_step   == '0) ? LEVEL_ONE : decay_step;
        release_eff   = (release_step == '0) ? LEVEL_ONE : release_step;

        attack_sum    = {1'b0, env_level} + {1'b0, attack_eff};
        decay_diff    = {1'b0, env_level} - {1'b0, decay_eff};
        release_diff  = {1'b0, env_level} - {1'b0, release_eff};

        attack_full   = (attack_sum >= {1'b0, LEVEL_MAX});
        attack_level  = attack_full ? LEVEL_MAX : attack_sum[ENV_WIDTH-1:0];
        decay_done    = decay_diff[ENV_WIDTH] ||
                        (decay_diff[ENV_WIDTH-1:0] <= sustain_level);
        release_done  = release_diff[ENV_WIDTH] ||
                        (release_diff[ENV_WIDTH-1:0] == '0);
        release_level = release_done ? '0 : release_diff[ENV_WIDTH-1:0];

        // A rising gate only counts when retriggering is built in.
        retrigger     = RETRIGGER_EN & gate & ~gate_prev;
    end

    // Envelope next-state decision, evaluated only on tick cycles. Gate low
    // is checked first in every sounding state so a note-off always beats a
    // same-tick ATTACK->DECAY or DECAY->SUSTAIN hand-over. A retrigger keeps
    // the current level and adds the attack step on the same tick, so there
    // is no audible drop to zero.
    always_comb begin
        next_state = state;
        next_level = env_level;
        if (tick) begin
            case (state)
                IDLE: begin
                    next_level = '0;
                    if (gate) begin
                        next_state = ATTACK;
                        next_level = attack_level;
                    end
                end
                ATTACK: begin
                    if (!gate) begin
                        next_state = RELEASE;
                        next_level = release_level;
                    end else if (attack_full) begin
                        next_state = DECAY;
                        next_level = LEVEL_MAX;
                    end else begin
                        next_level = attack_level;
                    end
                end
                DECAY: begin
                    if (!gate) begin
                        next_state = RELEASE;
                        next_level = release_level;
                    end else if (retrigger) begin
                        next_state = ATTACK;
                        next_level = attack_level;
                    end else if (decay_done) begin
                        next_state = SUSTAIN;
                        next_level = sustain_level;
                    end else begin
                        next_level = decay_diff[ENV_WIDTH-1:0];
                    end
                end
                SUSTAIN: begin
                    if (!gate) begin
                        next_state = RELEASE;
                        next_level = release_level;
                    end else if (retrigger) begin
                        next_state = ATTACK;
                        next_level = attack_level;
                    end else begin
                        next_level = sustain_level;
                    end
                end
                RELEASE: begin
                    if (retrigger) begin
                        next_state = ATTACK;
                        next_level = attack_level;
                    end else if (release_done) begin
                        next_state = IDLE;
                        next_level = '0;
                    end else begin
                        next_level = release_level;
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_level = '0;
                end
            endcase
        end
    end

    // All state lives here: envelope FSM, registered busy flag, the gate
    // history used for edge detection, and the two-stage multiply pipeline.
    // busy is derived from next_state so it always agrees with env_state.
    // The output stage keeps the top DATA_WIDTH bits of the product, which
    // makes full scale 0xFFFF * 0xFFFF land on 0xFFFE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            env_level  <= '0;
            busy       <= 1'b0;
            gate_prev  <= 1'b0;
            product_q  <= '0;
            sample_out <= '0;
        end else begin
            state      <= next_state;
            env_level  <= next_level;
            busy       <= (next_state != IDLE);
            if (tick) begin
                gate_prev <= gate;
            end
            product_q  <= PROD_WIDTH'(wave_in) * PROD_WIDTH'(env_level);
            sample_out <= DATA_WIDTH'(product_q >> ENV_WIDTH);
        end
    end

endmodule

// File: tb/tb_adsr_envelope_stage.sv
// ---------------------------------------------------------------------------
// tb_adsr_envelope_stage
//
// Purpose:
//    Self-checking bench for adsr_envelope_stage: a table of tick/gate
//    vectors through a full note, hand-written corner sequences (reset
//    mid-note, datapath latency and full scale, zero step, gate drop in
//    ATTACK, retrigger in RELEASE) and a randomized run against an
//    integer reference model of the envelope and multiply pipeline.
//    Honours ADSR_RETRIGGER_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_adsr_envelope_stage;

    localparam int LMAX = 65535;

`ifdef ADSR_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        gate;
    logic [15:0] attack_step;
    logic [15:0] decay_step;
    logic [15:0] sustain_level;
    logic [15:0] release_step;
    logic [15:0] wave_in;
    logic [15:0] sample_out;
    logic [15:0] env_level;
    logic [2:0]  env_state;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference model: plain integers, updated once per clock edge.
    int     m_state = 0;
    int     m_level = 0;
    bit     m_gp    = 1'b0;
    longint m_prod  = 0;
    int     m_out   = 0;

    typedef struct {
        bit tick;
        bit gate;
        int exp_state;
        int exp_level;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    adsr_envelope_stage #(.DATA_WIDTH(16), .ENV_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .gate          (gate),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .wave_in       (wave_in),
        .sample_out    (sample_out),
        .env_level     (env_level),
        .env_state     (env_state),
        .busy          (busy)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit t, input bit g);
        tick = t;
        gate = g;
    endtask

    function automatic int effStep(input logic [15:0] s);
        return (s == 16'd0) ? 1 : int'(s);
    endfunction

    // Envelope rules written directly from the behaviour: add/subtract
    // with clamping, state as a small integer.
    task automatic modelEdge();
        int     att, dec, rel, sus;
        bit     rise;
        longint prod_next;
        if (rst) begin
            m_state = 0; m_level = 0; m_gp = 1'b0; m_prod = 0; m_out = 0;
            return;
        end
        prod_next = longint'(wave_in) * longint'(m_level);
        m_out     = int'(m_prod >> 16);
        m_prod    = prod_next;
        if (tick) begin
            att  = effStep(attack_step);
            dec  = effStep(decay_step);
            rel  = effStep(release_step);
            sus  = int'(sustain_level);
            rise = gate && !m_gp;
            if (m_state != 0 && m_state != 4 && !gate) begin
                m_level = (m_level - rel < 0) ? 0 : m_level - rel;
                m_state = 4;
            end else if (m_state >= 2 && RETRIG && rise) begin
                m_level = (m_level + att > LMAX) ? LMAX : m_level + att;
                m_state = 1;
            end else begin
                case (m_state)
                    0: if (gate) begin m_state = 1; m_level = att; end
                    1: begin
                        m_level = m_level + att;
                        if (m_level >= LMAX) begin m_level = LMAX; m_state = 2; end
                    end
                    2: begin
                        m_level = m_level - dec;
                        if (m_level <= sus) begin m_level = sus; m_state = 3; end
                    end
                    3: m_level = sus;
                    default: begin
                        m_level = m_level - rel;
                        if (m_level <= 0) begin m_level = 0; m_state = 0; end
                    end
                endcase
            end
            m_gp = gate;
        end
    endtask

    task automatic runCycle(input bit compare_model);
        modelEdge();
        @(posedge clk);
        #1;
        if (compare_model) begin
            checkOutput("rnd_state", longint'(env_state), longint'(m_state));
            checkOutput("rnd_level", longint'(env_level), longint'(m_level));
            checkOutput("rnd_busy", longint'(busy), longint'(m_state != 0));
            checkOutput("rnd_sample", longint'(sample_out), longint'(m_out));
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0);
        rst = 1'b1;
        runCycle(1'b0);
        runCycle(1'b0);
        rst = 1'b0;
    endtask

    task automatic tickCheck(input bit g, input int st, input int lv, input string name);
        applyStimulus(1'b1, g);
        runCycle(1'b0);
        checkOutput({name, "_state"}, longint'(env_state), longint'(st));
        checkOutput({name, "_level"}, longint'(env_level), longint'(lv));
    endtask

    function automatic logic [15:0] randStep();
        case ($urandom_range(0, 3))
            0:       return 16'd0;
            1:       return 16'($urandom_range(1, 16));
            2:       return 16'($urandom_range(16'h1000, 16'hFFFF));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; tick = 1'b0; gate = 1'b0;
        attack_step = 16'h4000; decay_step = 16'h1000;
        sustain_level = 16'h8000; release_step = 16'h2000;
        wave_in = 16'h0000;

        // Power-on reset state.
        doReset();
        checkOutput("reset_state", longint'(env_state), 0);
        checkOutput("reset_level", longint'(env_level), 0);
        checkOutput("reset_busy", longint'(busy), 0);
        checkOutput("reset_sample", longint'(sample_out), 0);

        // Full note: 20 gated ticks, then release to IDLE.
        vecs.push_back('{1'b1, 1'b1, 1, 'h4000});
        vecs.push_back('{1'b1, 1'b1, 1, 'h8000});
        vecs.push_back('{1'b0, 1'b0, 1, 'h8000});
        vecs.push_back('{1'b1, 1'b1, 1, 'hC000});
        vecs.push_back('{1'b1, 1'b1, 2, 'hFFFF});
        for (int k = 1; k <= 7; k++) vecs.push_back('{1'b1, 1'b1, 2, 'hFFFF - k * 'h1000});
        vecs.push_back('{1'b1, 1'b1, 3, 'h8000});
        for (int k = 0; k < 8; k++) vecs.push_back('{1'b1, 1'b1, 3, 'h8000});
        vecs.push_back('{1'b1, 1'b0, 4, 'h6000});
        vecs.push_back('{1'b1, 1'b0, 4, 'h4000});
        vecs.push_back('{1'b1, 1'b0, 4, 'h2000});
        vecs.push_back('{1'b0, 1'b1, 4, 'h2000});
        vecs.push_back('{1'b1, 1'b0, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 0, 0});
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].tick, vecs[i].gate);
            runCycle(1'b0);
            checkOutput($sformatf("vec%0d_state", i), longint'(env_state), longint'(vecs[i].exp_state));
            checkOutput($sformatf("vec%0d_level", i), longint'(env_level), longint'(vecs[i].exp_level));
            checkOutput($sformatf("vec%0d_busy", i), longint'(busy), longint'(vecs[i].exp_state != 0));
        end

        // Reset mid-SUSTAIN with tick and gate still asserted.
        doReset();
        attack_step = 16'hFFFF; decay_step = 16'h1000; sustain_level = 16'hF000;
        wave_in = 16'hFFFF;
        tickCheck(1'b1, 1, 'hFFFF, "rs_att");
        tickCheck(1'b1, 2, 'hFFFF, "rs_dec");
        tickCheck(1'b1, 3, 'hF000, "rs_sus");
        applyStimulus(1'b0, 1'b1);
        runCycle(1'b0);
        runCycle(1'b0);
        checkOutput("rs_sample", longint'(sample_out), 'hEFFF);
        applyStimulus(1'b1, 1'b1);
        rst = 1'b1;
        runCycle(1'b0);
        runCycle(1'b0);
        rst = 1'b0;
        checkOutput("rs_state", longint'(env_state), 0);
        checkOutput("rs_level", longint'(env_level), 0);
        checkOutput("rs_out", longint'(sample_out), 0);
        checkOutput("rs_busy", longint'(busy), 0);

        // Datapath latency and full scale.
        doReset();
        wave_in = 16'h0000; attack_step = 16'hFFFF; sustain_level = 16'h8000;
        tickCheck(1'b1, 1, 'hFFFF, "dp_att");
        tickCheck(1'b1, 2, 'hFFFF, "dp_dec");
        applyStimulus(1'b0, 1'b1);
        runCycle(1'b0);
        runCycle(1'b0);
        wave_in = 16'hFFFF;
        runCycle(1'b0);
        checkOutput("dp_lat1", longint'(sample_out), 0);
        runCycle(1'b0);
        checkOutput("dp_full", longint'(sample_out), 'hFFFE);
        decay_step = 16'hFFFF;
        tickCheck(1'b1, 3, 'h8000, "dp_sus");
        applyStimulus(1'b0, 1'b1);
        runCycle(1'b0);
        checkOutput("dp_hold", longint'(sample_out), 'hFFFE);
        runCycle(1'b0);
        checkOutput("dp_half", longint'(sample_out), 'h7FFF);

        // Zero attack step counts up by one.
        doReset();
        attack_step = 16'h0000;
        tickCheck(1'b1, 1, 1, "zs1");
        tickCheck(1'b1, 1, 2, "zs2");
        tickCheck(1'b1, 1, 3, "zs3");

        // Gate drop during ATTACK releases on the same tick.
        doReset();
        attack_step = 16'h4000; release_step = 16'h1000;
        tickCheck(1'b1, 1, 'h4000, "gd_a1");
        tickCheck(1'b1, 1, 'h8000, "gd_a2");
        tickCheck(1'b0, 4, 'h7000, "gd_rel");

        // Rising gate while in RELEASE.
        doReset();
        attack_step = 16'h4000; release_step = 16'h1000;
        tickCheck(1'b1, 1, 'h4000, "rt_att");
        tickCheck(1'b0, 4, 'h3000, "rt_rel");
`ifdef ADSR_RETRIGGER_EN
        tickCheck(1'b1, 1, 'h7000, "rt_edge");
        tickCheck(1'b1, 1, 'hB000, "rt_cont");
`else
        tickCheck(1'b1, 4, 'h2000, "rt_edge");
        tickCheck(1'b1, 4, 'h1000, "rt_r2");
        tickCheck(1'b1, 0, 0, "rt_idle");
        tickCheck(1'b1, 1, 'h4000, "rt_restart");
`endif

        // Randomized run against the reference model.
        doReset();
        gate = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            rst  = ($urandom_range(0, 399) == 0);
            tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 24) == 0) gate = ~gate;
            if ($urandom_range(0, 39) == 0) attack_step  = randStep();
            if ($urandom_range(0, 39) == 0) decay_step   = randStep();
            if ($urandom_range(0, 39) == 0) release_step = randStep();
            if ($urandom_range(0, 59) == 0) sustain_level = 16'($urandom);
            wave_in = 16'($urandom);
            runCycle(1'b1);
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adsr_envelope_stage.md
# adsr_envelope_stage

Envelope stage directly downstream of the subtractive waveform source: takes the unsigned oscillator sample each clock and multiplies it by a piecewise-linear ADSR gain driven by a note gate. Envelope state advances only on `tick` (sample-rate strobe); the multiply path runs every cycle. Output feeds the voice mixer/DAC path.

## Interface
- `DATA_WIDTH`, 16, width of the waveform sample in/out
- `ENV_WIDTH`, 16, width of envelope level and step/sustain inputs
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high; one clock; all state sampled on rising `clk`
- `tick`  in  1  envelope update strobe, one-cycle pulse
- `gate`  in  1  note on (1) / off (0)
- `attack_step`  in  ENV_WIDTH  level increment per tick in ATTACK
- `decay_step`  in  ENV_WIDTH  level decrement per tick in DECAY
- `sustain_level`  in  ENV_WIDTH  hold level in SUSTAIN
- `release_step`  in  ENV_WIDTH  level decrement per tick in RELEASE
- `wave_in`  in  DATA_WIDTH  unsigned oscillator sample
- `sample_out`  out  DATA_WIDTH  enveloped sample
- `env_level`  out  ENV_WIDTH  current envelope level
- `env_state`  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- `busy`  out  1  high when `env_state` != IDLE

## Operation
- State transitions and level updates occur only on cycles with `tick`=1; without `tick`, state and level hold.
- A step input of 0 is treated as 1 (no lock-up).
- Arithmetic: level updates use ENV_WIDTH+1-bit intermediates; saturating, never wraps.
- IDLE: level=0. On tick with `gate`=1 -> ATTACK; level is updated on that same tick (0 + attack_step).
- ATTACK: level += attack_step; when sum >= 2^ENV_WIDTH-1, level = max and -> DECAY.
- DECAY: level -= decay_step; when result <= sustain_level (or underflows), level = sustain_level and -> SUSTAIN.
- SUSTAIN: level = `sustain_level` every tick (tracks live changes).
- Gate low, sampled on a tick in ATTACK, DECAY or SUSTAIN -> RELEASE; level is decremented by release_step on that same tick.
- RELEASE: level -= release_step; on result <= 0, level = 0 and -> IDLE.
- Gate low wins over any same-tick ATTACK->DECAY or DECAY->SUSTAIN transition.
- `gate_prev` register captures `gate` on each tick, for rising-edge detection (see Configuration).
- Datapath: product = wave_in * env_level (DATA_WIDTH+ENV_WIDTH bits); `sample_out` = product[DATA_WIDTH+ENV_WIDTH-1 : ENV_WIDTH]. Full scale: 0xFFFF * 0xFFFF -> 0xFFFE.

## Timing
- Reset: env_state=IDLE, env_level=0, sample_out=0, busy=0, gate_prev=0, pipeline registers=0. Applies mid-note: the next edge with rst=1 clears everything regardless of tick/gate.
- `env_level`/`env_state` change on the clock edge where `tick`=1 is sampled (1-cycle latency from tick).
- `sample_out` latency: 2 cycles from `wave_in` and `env_level` (stage 1 registers the product, stage 2 registers the truncated output).
- `busy` is registered, consistent with `env_state` in the same cycle.

## Configuration
- `ADSR_RETRIGGER_EN` defined: a gate rising edge (gate=1, gate_prev=0 on a tick) in DECAY, SUSTAIN or RELEASE -> ATTACK, continuing from the current level (no click to 0). In ATTACK the edge is a no-op.
- Not defined: rising edges outside IDLE are ignored. RELEASE runs to IDLE. The next tick with gate=1 then starts ATTACK from 0.

## Test plan
- Reset: drive rst=1 for 2 cycles mid-SUSTAIN -> env_state=0, env_level=0, sample_out=0, busy=0.
- Full cycle: attack_step=0x4000, decay_step=0x1000, sustain=0x8000, release_step=0x2000, gate=1 for 20 ticks, then 0 -> levels 0x4000, 0x8000, 0xC000, 0xFFFF (DECAY) … 0x8000 (SUSTAIN) -> release 0x6000 … 0 -> IDLE.
- Datapath: wave_in=0xFFFF, level held 0x8000 -> sample_out=0x7FFF, appearing 2 cycles after inputs settle. Level 0xFFFF -> 0xFFFE.
- Zero step: attack_step=0, gate=1 -> level increments by 1 per tick.
- Gate drop in ATTACK at level 0x8000, release_step=0x1000 -> same tick: RELEASE, level 0x7000.
- Retrigger: in RELEASE at level 0x3000, gate 0->1 on a tick. With ADSR_RETRIGGER_EN -> ATTACK, level 0x3000+attack_step. Without the macro -> stays in RELEASE until IDLE, then ATTACK from 0.
